// File: rtl/ads1675_serial_emulator_if.sv
// ----------------------------------------------------------------------------
// ads1675_serial_emulator_if
//   Sample stream handshake carrying parallel two's-complement samples into
//   the ADS1675 serial emulator.
//
//   Signals:
//     tvalid  source -> sink  sample valid
//     tready  sink -> source  sample accepted when tvalid & tready
//     tdata   source -> sink  DW-bit sample
//
//   Modports:
//     master  the sample source (drives tvalid/tdata, observes tready)
//     slave   the emulator (observes tvalid/tdata, drives tready)
// ----------------------------------------------------------------------------
interface ads1675_serial_emulator_if #(
    parameter int DW = 24
) ();
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/ads1675_serial_emulator.sv
// ----------------------------------------------------------------------------
// ads1675_serial_emulator
//   Transmitter emulating the ADS1675 serial output (DRDY + DOUT) on the
//   ADC-side shift clock. Each frame of FRAME_LEN sclk cycles carries one
//   DW-bit sample MSB first, ending right before a DRDY_W-cycle DRDY pulse,
//   so a capture path that registers DOUT/DRDY once and latches the last DW
//   bits on the DRDY rising edge recovers the sample exactly. Samples come
//   from a one-entry holding buffer fed by a stream handshake, or from an
//   internal ramp when pattern_en is set.
//
//   Ports:
//     sclk        in   shift clock, all logic on its rising edge
//     areset_n    in   synchronous active-low reset
//     start       in   ADC START pin, frames run only while high
//     cs_n        in   chip select, active-low
//     pown        in   power-down, active-low
//     pattern_en  in   1 = send internal ramp, ignore the stream
//     s_axis      --   sample stream (slave side: tvalid, tready, tdata)
//     drdy        out  registered data-ready strobe
//     dout        out  registered serial data, MSB first
//     underrun    out  one-cycle pulse when a frame is loaded with no fresh
//                      sample (previous sample is repeated)
//     frame_cnt   out  frames completed, wraps at 2^16
// ----------------------------------------------------------------------------
module ads1675_serial_emulator #(
    parameter int DW        = 24,
    parameter int FRAME_LEN = 32,
    parameter int DRDY_W    = 4
) (
    input  logic                            sclk,
    input  logic                            areset_n,
    input  logic                            start,
    input  logic                            cs_n,
    input  logic                            pown,
    input  logic                            pattern_en,
    ads1675_serial_emulator_if.slave        s_axis,
    output logic                            drdy,
    output logic                            dout,
    output logic                            underrun,
    output logic [15:0]                     frame_cnt
);

    localparam int CW = $clog2(FRAME_LEN);

    // Phase landmarks within a frame. Entering RUN at LOAD means the first
    // frame after run rises already carries a fully loaded word.
    localparam logic [CW-1:0] LOAD      = CW'(FRAME_LEN - DW - 1);
    localparam logic [CW-1:0] LAST      = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] DRDY_END  = CW'(DRDY_W);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [DW-1:0] shreg;
    logic [DW-1:0] buf_data;
    logic          buf_full;
    logic [DW-1:0] last_sample;
    logic [DW-1:0] ramp;
    logic [DW-1:0] load_word;
    logic          run;
    logic          in_load;
    logic          accept;

    assign run      = start & ~cs_n & pown;
    assign in_load  = (state == ST_RUN) && (cnt == LOAD) && run;
    assign accept   = s_axis.tvalid & ~buf_full;
    assign cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);

    // Registered ready: no combinational path from tvalid to tready.
    assign s_axis.tready = ~buf_full;

    assign load_word = pattern_en ? ramp : (buf_full ? buf_data : last_sample);
    assign underrun  = areset_n & in_load & ~pattern_en & ~buf_full;

    always_ff @(posedge sclk) begin
        if (!areset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            shreg       <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            last_sample <= '0;
            ramp        <= '0;
            drdy        <= 1'b0;
            dout        <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            // Buffer can never be both filled and drained in one cycle:
            // a fill needs it empty, a drain needs it full.
            if (accept) begin
                buf_full <= 1'b1;
                buf_data <= s_axis.tdata;
            end

            case (state)
                ST_IDLE: begin
                    drdy <= 1'b0;
                    dout <= 1'b0;
                    if (run) begin
                        state <= ST_RUN;
                        cnt   <= LOAD;
                    end
                end

                default: begin
                    if (!run) begin
                        // Abandon the partial frame; buffer and ramp persist.
                        state <= ST_IDLE;
                        drdy  <= 1'b0;
                        dout  <= 1'b0;
                    end else begin
                        cnt  <= cnt_next;
                        drdy <= (cnt_next < DRDY_END);

                        if (cnt == LAST) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end

                        // Outputs are registered, so they are computed for
                        // cnt_next: the MSB leaves in the cycle after LOAD.
                        if (cnt == LOAD) begin
                            dout  <= load_word[DW-1];
                            shreg <= {load_word[DW-2:0], 1'b0};
                            if (pattern_en) begin
                                ramp <= ramp + DW'(1);
                            end else if (buf_full) begin
                                buf_full    <= 1'b0;
                                last_sample <= buf_data;
                            end
                        end else if ((cnt > LOAD) && (cnt != LAST)) begin
                            dout  <= shreg[DW-1];
                            shreg <= {shreg[DW-2:0], 1'b0};
                        end else begin
                            dout <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ads1675_serial_emulator.md
Name: ads1675_serial_emulator

Overview:
- Synthesizable transmitter for the ADS1675 serial output interface, running on the ADC-side shift clock.
- Takes parallel 24-bit samples over a stream handshake (or generates an internal ramp) and drives single-ended DRDY and DOUT.
- The DOUT timing lets an FPGA capture path that registers DOUT/DRDY once and latches the last DW shifted bits on the detected DRDY rising edge recover each sample exactly.
- Used for board-less loopback of the DAQ capture chain; LVDS output buffers sit outside this block.

Parameters:
- DW, 24: sample width; bits per frame on DOUT.
- FRAME_LEN, 32: sclk cycles per output frame (sample period). Required: FRAME_LEN >= DW+DRDY_W+1.
- DRDY_W, 4: DRDY high pulse width in sclk cycles, 1..FRAME_LEN-DW-1.

Ports:
- sclk  in  1  shift clock; all logic is on its rising edge.
- areset_n  in  1  reset, synchronous, active-low, clock sclk.
- start  in  1  ADC START pin; frames run only while high.
- cs_n  in  1  chip select, active-low; run requires 0.
- pown  in  1  power-down, active-low; run requires 1.
- pattern_en  in  1  1 = send internal ramp, ignore stream.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  sample accepted when tvalid & tready.
- s_axis_tdata  in  DW  two's-complement sample.
- drdy  out  1  data-ready strobe, registered.
- dout  out  1  serial data, MSB first, registered.
- underrun  out  1  one-cycle pulse: frame loaded with no fresh sample.
- frame_cnt  out  16  frames completed, wraps at 2^16.

Behaviour:
- run = start & ~cs_n & pown, combinational.
- Reset values: drdy=0, dout=0, underrun=0, frame_cnt=0, holding buffer empty (s_axis_tready=1), last sample=0, ramp=0, state IDLE.
- Holding buffer is one entry. s_axis_tready = ~buf_full, driven from a register with no combinational path from tvalid. A handshake fills the buffer.
- States:
  - IDLE: drdy=0, dout=0. When run=1, go to RUN with phase cnt=LOAD, where LOAD = FRAME_LEN-DW-1.
  - RUN: cnt counts 0..FRAME_LEN-1 and wraps to 0.
- Load cycle (cnt==LOAD), source of the DW-bit shift register:
  - pattern_en=1: load ramp, then ramp += 1 (mod 2^DW). Buffer untouched; underrun=0.
  - else if buf_full: load buffer, clear buf_full, update last sample.
  - else: load last sample again and pulse underrun.
  - tready stays 0 in the load cycle when the buffer was full; a new handshake becomes possible from the next cycle.
- Data window: for cnt in FRAME_LEN-DW..FRAME_LEN-1, dout = shift-register bit DW-1-(cnt-(FRAME_LEN-DW)), so the MSB comes first. Outside the window dout=0.
- drdy = 1 for cnt in 0..DRDY_W-1, else 0. Its rising edge is therefore the cycle right after the LSB.
- frame_cnt increments when cnt wraps FRAME_LEN-1 -> 0.
- Consequence of entering at LOAD: the first DRDY after run rises follows a fully valid word; no garbage frame is produced.
- run falls in any state: next cycle is IDLE with drdy=0, dout=0. The partial frame is abandoned. Buffer contents and ramp are kept, and frame_cnt does not increment.
- areset_n=0 mid-frame: all state returns to reset values on the next edge, including loss of the buffered sample.
- pattern_en is sampled only in the load cycle; changing it mid-frame does not affect the word being shifted.
- Output latency: a sample accepted while IDLE appears MSB-first on dout starting 1 cycle after the load cycle, i.e. 2 cycles after run rises.

Test Plan:
1. Reset: hold areset_n=0 for 3 cycles with run=1 -> drdy=0, dout=0, tready=1, underrun=0, frame_cnt=0. After release, state leaves IDLE on the next edge.
2. Single word: push 0xA5F00F, then run=1 -> dout carries 1010_0101_1111_0000_0000_1111 over 24 cycles, then drdy is high for 4 cycles. A loopback capture model (1-cycle input regs, latch on detected rise) yields 0xA5F00F. frame_cnt=1 after the wrap.
3. Back-to-back: tvalid held with 0x800000, 0x7FFFFF, 0x000001 -> one accept per 32-cycle frame, tready low exactly from fill until the load cycle. Words arrive in order; drdy rises every 32 cycles.
4. Underrun: one word 0x123456, then no tvalid for 3 frames -> 0x123456 is repeated in frames 2-4, and underrun pulses once per frame in each load cycle.
5. Run drop: deassert start at cnt=10 of frame 2 -> drdy=0, dout=0 next cycle and frame_cnt stays 1. Re-assert start -> first drdy after 25 cycles carries the buffered word.
6. Pattern: pattern_en=1 for 4 frames from reset -> words 0,1,2,3, tready stays 1, no underrun. With ramp forced to 0xFFFFFF, the following frame sends 0x000000.
